// File: rtl/chip8_pkg.sv
// chip8_pkg
// Shared definitions for the CHIP-8 8XYN sequencer slice:
//   - opcode nibble constants for the 8XYN family
//   - index of the flag register VF
//   - seq_state_t, the sequencer state encoding
//   - is_legal_8xyn(), the legality test applied when an opcode is launched
package chip8_pkg;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_RSB = 4'h7;
  localparam logic [3:0] OP_SHL = 4'hE;

  localparam logic [3:0] VF_IDX = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB_X,
    S_WB_F,
    S_DONE
  } seq_state_t;

  // Legal: top nibble 8 and N in 0..7 or E.
  function automatic logic is_legal_8xyn(input logic [15:0] op);
    return (op[15:12] == 4'h8) && ((op[3] == 1'b0) || (op[3:0] == OP_SHL));
  endfunction

endpackage

// File: rtl/chip8_vregs.sv
// chip8_vregs
// The sixteen 8-bit CHIP-8 V registers.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears all registers)
//   we, waddr, wdata  single synchronous write port
//   raddr_a, rdata_a  asynchronous read port A
//   raddr_b, rdata_b  asynchronous read port B
module chip8_vregs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [3:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] regs_reg [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_reg[i] <= 8'h00;
    end else if (we) begin
      regs_reg[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_reg[raddr_a];
  assign rdata_b = regs_reg[raddr_b];

endmodule

// File: rtl/chip8_alu_seq.sv
// chip8_alu_seq
// Sequencer for CHIP-8 8XYN register-to-register instructions. Owns the V
// register file, presents latched operands to an external ALU and writes back
// Vx, then VF when the ALU (or the quirk) asks for a flag update.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, instr                 launch handshake (sampled only in IDLE)
//   busy, done, illegal          status; done/illegal are one-cycle pulses
//   alu_a, alu_b, alu_op         latched operands and N nibble to the ALU
//   alu_out, alu_vf_we, alu_carry  ALU result, VF-write request, flag bit
//   ext_we, ext_waddr, ext_wdata CPU write port, honoured only when idle
//   ext_raddr, ext_rdata         CPU combinational read port
// Build option: CHIP8_VF_RESET_QUIRK_EN makes OR/AND/XOR clear VF.
module chip8_alu_seq
  import chip8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_out,
  input  logic        alu_vf_we,
  input  logic        alu_carry,
  input  logic        ext_we,
  input  logic [3:0]  ext_waddr,
  input  logic [7:0]  ext_wdata,
  input  logic [3:0]  ext_raddr,
  output logic [7:0]  ext_rdata
);

  seq_state_t state_reg;
  logic [3:0] x_reg, y_reg, op_reg;
  logic [7:0] alu_a_reg, alu_b_reg, res_reg;
  logic       flg_reg, fwe_reg, done_reg, illegal_reg;

  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [3:0] rf_raddr_b;
  logic [7:0] rdata_x, rdata_b;
  logic       flg_next, fwe_next;

  // Port B serves the CPU read port except during the single READ cycle,
  // where it fetches Vy. The CPU does not use the side port while busy.
  assign rf_raddr_b = (state_reg == S_READ) ? y_reg : ext_raddr;

  chip8_vregs u_vregs (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (x_reg),
    .rdata_a (rdata_x),
    .raddr_b (rf_raddr_b),
    .rdata_b (rdata_b)
  );

  // Write-port mux: write-back owns the port in WB_X/WB_F, the CPU only in IDLE.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ext_waddr;
    rf_wdata = ext_wdata;
    case (state_reg)
      S_IDLE: rf_we = ext_we;
      S_WB_X: begin
        rf_we    = 1'b1;
        rf_waddr = x_reg;
        rf_wdata = res_reg;
      end
      S_WB_F: begin
        rf_we    = 1'b1;
        rf_waddr = VF_IDX;
        rf_wdata = {7'b0, flg_reg};
      end
      default: ;
    endcase
  end

`ifdef CHIP8_VF_RESET_QUIRK_EN
  // COSMAC VIP behaviour: logic ops always clear VF.
  always_comb begin
    fwe_next = alu_vf_we;
    flg_next = alu_carry;
    if (op_reg == OP_OR || op_reg == OP_AND || op_reg == OP_XOR) begin
      fwe_next = 1'b1;
      flg_next = 1'b0;
    end
  end
`else
  always_comb begin
    fwe_next = alu_vf_we;
    flg_next = alu_carry;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      x_reg       <= 4'h0;
      y_reg       <= 4'h0;
      op_reg      <= 4'h0;
      alu_a_reg   <= 8'h00;
      alu_b_reg   <= 8'h00;
      res_reg     <= 8'h00;
      flg_reg     <= 1'b0;
      fwe_reg     <= 1'b0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            x_reg  <= instr[11:8];
            y_reg  <= instr[7:4];
            op_reg <= instr[3:0];
            if (is_legal_8xyn(instr)) begin
              state_reg <= S_READ;
            end else begin
              state_reg   <= S_DONE;
              done_reg    <= 1'b1;
              illegal_reg <= 1'b1;
            end
          end
        end
        S_READ: begin
          alu_a_reg <= rdata_x;
          alu_b_reg <= rdata_b;
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          res_reg   <= alu_out;
          flg_reg   <= flg_next;
          fwe_reg   <= fwe_next;
          state_reg <= S_WB_X;
        end
        S_WB_X: begin
          if (fwe_reg) begin
            state_reg <= S_WB_F;
          end else begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
        end
        S_WB_F: begin
          state_reg <= S_DONE;
          done_reg  <= 1'b1;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign illegal   = illegal_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = op_reg;
  assign ext_rdata = rdata_b;

endmodule

// File: doc/chip8_alu_seq.md
# chip8_alu_seq

Sequencer for CHIP-8 8XYN register-to-register instructions. It owns the sixteen 8-bit V registers, reads Vx and Vy, drives the combinational ALU, and writes back Vx and then VF over a fixed multi-cycle schedule. The CPU control FSM launches it with a start/done handshake and uses a side port for all other register traffic.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  launch request; sampled only in IDLE
- instr  in  16  full opcode; latched when start is accepted
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse with done when instr is not a legal 8XYN
- alu_a  out  8  latched Vx operand
- alu_b  out  8  latched Vy operand
- alu_op  out  4  latched N nibble
- alu_out  in  8  ALU result
- alu_vf_we  in  1  ALU request to update VF
- alu_carry  in  1  ALU carry/borrow/shifted-out bit
- ext_we  in  1  CPU write strobe; honoured only while busy=0
- ext_waddr  in  4  CPU write register index
- ext_wdata  in  8  CPU write data
- ext_raddr  in  4  CPU read register index
- ext_rdata  out  8  combinational read of V[ext_raddr]

## Operation
- States: IDLE, READ, EXEC, WB_X, WB_F, DONE.
- IDLE: if start=1, latch instr and check legality.
  - Legal means instr[15:12]=0x8 and N in {0–7, E}. Legal goes to READ.
  - Illegal goes to DONE with the illegal flag set.
- READ: latch alu_a=V[X] and alu_b=V[Y], then go to EXEC.
- EXEC: register alu_out into res, register alu_carry into flg, and register the VF-write decision into fwe. Go to WB_X.
- WB_X: write V[X]=res. If fwe=1, go to WB_F; otherwise go to DONE.
- WB_F: write V[F]={7'b0,flg}, then go to DONE.
  - Because VF is written after Vx, the flag wins when X=F.
- DONE: assert done, assert illegal if flagged, clear the flag, return to IDLE.
- ext_we while busy=1 is dropped silently.
- ext_we together with start in IDLE: the external write occurs at that edge, and READ sees the new value.
- start while busy=1 is ignored and is not queued.
- Width rules: all data is 8-bit and truncated; VF holds only 0x00 or 0x01 after a flag write.

## Timing
- Reset: all V registers 0x00, state IDLE, busy=0, done=0, illegal=0, alu_a/alu_b/alu_op=0.
- Reset takes effect immediately at any state and aborts an operation in flight. A write due that cycle does not occur.
- Start accepted at edge k:
  - READ at k+1, EXEC at k+2, WB_X at k+3.
  - WB_F at k+4, with done at k+5 (flag ops).
  - Or done at k+4 (no flag write).
- Illegal instr accepted at edge k: done and illegal both high during cycle k+1; no register changes.
- After done, a new start is accepted in the same cycle the FSM reaches IDLE. Back-to-back issue interval is therefore 5 or 6 cycles.
- ext_rdata is combinational from the register array and reflects writes one edge after they occur.

## Configuration
- CHIP8_VF_RESET_QUIRK_EN defined: for N=1/2/3 (OR/AND/XOR), fwe is forced to 1 and flg to 0. VF becomes 0x00 in WB_F, giving the original COSMAC VIP behaviour.
- Not defined: logic ops leave VF untouched, following alu_vf_we.

## Structure
- Shared package chip8_pkg holds:
  - Opcode nibble constants (LD=0, OR=1, AND=2, XOR=3, ADD=4, SUB=5, SHR=6, RSB=7, SHL=14) and VF_IDX=4'hF.
  - The seq_state_t enum.
- One natural sub-module: chip8_vregs. It is a 16x8 register file with one synchronous write port (muxed internal/external) and two asynchronous read ports. The sequencer instantiates it.
- The ALU stays external. Benches connect the real ALU.

## Test plan
- V1=0xF0, V2=0x20, start with 0x8124 → done at k+5; V1=0x10, VF=0x01.
- V3=0x05, V4=0x07, 0x8345 → V3=0xFE, VF=0x00.
- VF=0x81, 0x8F06 → VF=0x40 after WB_X, final VF=0x01 (flag overrides result).
- VF=0x55, V1=0x0F, V2=0xF0, 0x8121 → V1=0xFF, done at k+4, VF=0x55 with the macro off. With CHIP8_VF_RESET_QUIRK_EN: done at k+5, VF=0x00.
- 0x8128 and 0x9120 → done and illegal pulse at k+1, all registers unchanged. start=1 held during busy → exactly one execution.
- Assert rst_n=0 during WB_X of 0x8124 → all registers 0x00 immediately, busy=0. A subsequent ext_we and start work normally.
